// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point operand path: word layout,
// field positions and the loader state encoding.
package fp_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;

  localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;

  // Field positions within an ascending [0:FP_W-1] operand word
  localparam int SIGN     = 0;
  localparam int EXP_MSB  = 1;
  localparam int EXP_LSB  = 6;
  localparam int MANT_MSB = 7;
  localparam int MANT_LSB = 31;

  typedef logic [0:FP_W-1] fp_word_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    CLASSIFY,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero (sign ignored) and saturated exponent.
module fp_classify
  import fp_pkg::*;
(
  input  fp_word_t i_op,
  output logic     o_is_zero,
  output logic     o_is_exp_max
);

  assign o_is_zero    = (i_op[EXP_MSB:EXP_LSB] == '0) && (i_op[MANT_MSB:MANT_LSB] == '0);
  assign o_is_exp_max = (i_op[EXP_MSB:EXP_LSB] == EXP_MAX);

endmodule

// File: rtl/fp_operand_loader.sv
// Byte-stream operand loader for the FP adder: assembles A/B, commits both
// atomically, pulses the adder reset, then holds the operands for one adder pass.
module fp_operand_loader
  import fp_pkg::*;
#(
  parameter int HOLD_CYCLES = 32,
  parameter int TIMEOUT     = 64
) (
  input  logic          clock_100kHz,
  input  logic          reset,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [0:31]   op_A_out,
  output logic [0:31]   op_B_out,
  output logic          adder_rst_n,
  output logic          operands_valid,
  output logic [0:3]    class_out,
  output logic          frame_error
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  loader_state_t  r_state, w_state_next;
  logic [1:0]     r_byte_cnt;
  logic [HCW-1:0] r_hold_cnt;
  logic [TCW-1:0] r_idle_cnt;
  fp_word_t       r_shadow_a, r_shadow_b, r_op_a, r_op_b;
  logic [0:3]     r_class;
  logic           r_ready_en, r_adder_rst_n, r_frame_error;

  logic w_accept, w_last_byte, w_commit, w_idle_active, w_timeout;
  logic w_a_zero, w_a_max, w_b_zero, w_b_max;

  assign byte_ready     = r_ready_en && ((r_state == LOAD_A) || (r_state == LOAD_B));
  assign w_accept       = byte_valid && byte_ready;
  assign w_last_byte    = w_accept && (r_byte_cnt == 2'd3);
  assign w_commit       = w_last_byte && (r_state == LOAD_B);
  assign w_idle_active  = ((r_state == LOAD_A) && (r_byte_cnt != 2'd0)) || (r_state == LOAD_B);
  // Acceptance has priority: a byte on the terminal idle cycle keeps the frame alive
  assign w_timeout      = w_idle_active && !w_accept && (r_idle_cnt == TCW'(TIMEOUT - 1));

  assign op_A_out       = r_op_a;
  assign op_B_out       = r_op_b;
  assign class_out      = r_class;
  assign adder_rst_n    = r_adder_rst_n;
  assign frame_error    = r_frame_error;
  assign operands_valid = (r_state == HOLD);

  fp_classify u_class_a (.i_op(r_op_a), .o_is_zero(w_a_zero), .o_is_exp_max(w_a_max));
  fp_classify u_class_b (.i_op(r_op_b), .o_is_zero(w_b_zero), .o_is_exp_max(w_b_max));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) r_state <= LOAD_A;
    else        r_state <= w_state_next;
  end

  // NOTE: next-state defaults to the current state first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD_A:   if (w_timeout) w_state_next = LOAD_A;
                else if (w_last_byte) w_state_next = LOAD_B;
      LOAD_B:   if (w_timeout) w_state_next = LOAD_A;
                else if (w_last_byte) w_state_next = CLASSIFY;
      CLASSIFY: w_state_next = HOLD;
      HOLD:     if (r_hold_cnt == '0) w_state_next = LOAD_A;
      default:  w_state_next = LOAD_A;
    endcase
  end

  // NOTE: the shadow registers are reset too, so no partial frame can leak
  // across a reset into a later commit.
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      r_byte_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_shadow_a    <= '0;
      r_shadow_b    <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_class       <= '0;
      r_ready_en    <= 1'b0;
      r_adder_rst_n <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_ready_en    <= 1'b1;
      r_adder_rst_n <= !w_commit;
      r_frame_error <= w_timeout;

      if (w_timeout) begin
        r_byte_cnt <= '0;
        r_shadow_a <= '0;
        r_shadow_b <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_state == LOAD_A) r_shadow_a[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
        else                   r_shadow_b[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
      end

      if (w_commit) begin
        r_op_a <= r_shadow_a;
        r_op_b <= {r_shadow_b[0:23], byte_in};
      end

      if (!w_idle_active || w_accept || w_timeout) r_idle_cnt <= '0;
      else if (r_idle_cnt != TCW'(TIMEOUT))        r_idle_cnt <= r_idle_cnt + 1'b1;

      if (r_state == CLASSIFY)                        r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
      else if ((r_state == HOLD) && (r_hold_cnt != '0)) r_hold_cnt <= r_hold_cnt - 1'b1;

      if (r_state == CLASSIFY) r_class <= {w_a_zero, w_b_zero, w_a_max, w_b_max};
    end
  end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: frame loading, commit timing, hold
// window, classification, timeout discard and asynchronous reset abort.
module tb_fp_operand_loader;

  localparam int HOLD = 32;
  localparam int TMO  = 64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [0:31] op_A_out, op_B_out;
  logic        adder_rst_n;
  logic        operands_valid;
  logic [0:3]  class_out;
  logic        frame_error;

  int tests = 0;
  int fails = 0;
  logic gap_ready_ok;

  fp_operand_loader #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clock_100kHz  (clk),
    .reset         (rst_n),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .op_A_out      (op_A_out),
    .op_B_out      (op_B_out),
    .adder_rst_n   (adder_rst_n),
    .operands_valid(operands_valid),
    .class_out     (class_out),
    .frame_error   (frame_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, wait (bounded) for byte_ready, return #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    while (!byte_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("ready_wait", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        if (!byte_ready) gap_ready_ok = 1'b0;
      end
    end
  endtask

  // Sends bytes first..7 of frame {a,b}; returns #1 after the committing edge.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int gap, input int first);
    logic [63:0] f;
    f = {a, b};
    for (int i = first; i < 8; i++) send_byte(f[63-8*i -: 8], (i < 7) ? gap : 0);
  endtask

  // Observes the cycles after a commit edge; index 0 is the cycle right after it.
  task automatic watch_commit(input logic hold_valid, input logic [7:0] hold_byte,
                              output int rst_lows, output int valid_hi,
                              output int v_first, output int v_last, output int r_first);
    rst_lows = 0; valid_hi = 0; v_first = -1; v_last = -1; r_first = -1;
    byte_valid = hold_valid;
    byte_in    = hold_byte;
    for (int i = 0; i < HOLD + 8; i++) begin
      @(negedge clk);
      if (!adder_rst_n) rst_lows++;
      if (operands_valid) begin
        valid_hi++;
        if (v_first < 0) v_first = i;
        v_last = i;
      end
      if (byte_ready) begin
        r_first = i;
        break;
      end
    end
  endtask

  initial begin
    int rl, vh, vf, vl, rf;
    int err_cnt, err_idx;

    rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; gap_ready_ok = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_a", op_A_out, 32'h0);
    check("rst_op_b", op_B_out, 32'h0);
    check("rst_class", 32'(class_out), 32'h0);
    check("rst_valid", 32'(operands_valid), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
    check("rst_adder_rst", 32'(adder_rst_n), 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(byte_ready), 32'h0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(byte_ready), 32'h1);

    // Frame 1 back-to-back; first byte of frame 2 held valid during HOLD
    send_frame(32'h3F800000, 32'h40000000, 0, 0);
    check("f1_op_a", op_A_out, 32'h3F800000);
    check("f1_op_b", op_B_out, 32'h40000000);
    check("f1_rst_at_commit", 32'(adder_rst_n), 32'h0);
    check("f1_valid_at_commit", 32'(operands_valid), 32'h0);
    watch_commit(1'b1, 8'h80, rl, vh, vf, vl, rf);
    check("f1_rst_low_cycles", rl, 32'd1);
    check("f1_valid_cycles", vh, 32'd32);
    check("f1_valid_first", vf, 32'd1);
    check("f1_valid_last", vl, 32'd32);
    check("f1_ready_rise", rf, 32'd33);
    check("f1_class", 32'(class_out), 32'h0);
    check("f1_op_a_held", op_A_out, 32'h3F800000);
    @(posedge clk); #1;

    // Frame 2: A = -0, B exponent 63
    send_frame(32'h80000000, 32'h7E000001, 0, 1);
    check("f2_op_a", op_A_out, 32'h80000000);
    check("f2_op_b", op_B_out, 32'h7E000001);
    watch_commit(1'b0, 8'h00, rl, vh, vf, vl, rf);
    check("f2_class", 32'(class_out), 32'b1001);
    check("f2_valid_cycles", vh, 32'd32);

    // Frame 1 again with 5-cycle gaps between bytes
    gap_ready_ok = 1'b1;
    send_frame(32'h3F800000, 32'h40000000, 5, 0);
    check("gap_ready_held", 32'(gap_ready_ok), 32'h1);
    check("gap_op_a", op_A_out, 32'h3F800000);
    check("gap_op_b", op_B_out, 32'h40000000);
    watch_commit(1'b0, 8'h00, rl, vh, vf, vl, rf);
    check("gap_rst_low_cycles", rl, 32'd1);
    check("gap_valid_cycles", vh, 32'd32);
    check("gap_class", 32'(class_out), 32'h0);

    // Partial frame: 3 bytes of A then silence
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    byte_valid = 1'b0;
    err_cnt = 0; err_idx = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_error) begin
        err_cnt++;
        if (err_idx < 0) err_idx = i;
      end
    end
    check("tmo_pulse_count", err_cnt, 32'd1);
    check("tmo_pulse_cycle", err_idx, 32'd64);
    check("tmo_op_a_kept", op_A_out, 32'h3F800000);
    check("tmo_op_b_kept", op_B_out, 32'h40000000);
    check("tmo_class_kept", 32'(class_out), 32'h0);

    // Full frame after the discard: B zero
    send_frame(32'hC1200000, 32'h00000000, 0, 0);
    check("f3_op_a", op_A_out, 32'hC1200000);
    check("f3_op_b", op_B_out, 32'h00000000);
    byte_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("f3_valid_in_hold", 32'(operands_valid), 32'h1);
    check("f3_class", 32'(class_out), 32'b0100);

    // Asynchronous reset during HOLD cycle 10
    #2 rst_n = 1'b0;
    #1;
    check("arst_op_a", op_A_out, 32'h0);
    check("arst_op_b", op_B_out, 32'h0);
    check("arst_class", 32'(class_out), 32'h0);
    check("arst_valid", 32'(operands_valid), 32'h0);
    check("arst_adder_rst", 32'(adder_rst_n), 32'h0);
    check("arst_ready", 32'(byte_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready_pre_edge", 32'(byte_ready), 32'h0);
    @(posedge clk); #1;
    check("arst_ready_post_edge", 32'(byte_ready), 32'h1);
    check("arst_adder_rst_rel", 32'(adder_rst_n), 32'h1);

    // Clean frame after the abort
    send_frame(32'h3F800000, 32'h40000000, 0, 0);
    check("f4_op_a", op_A_out, 32'h3F800000);
    check("f4_op_b", op_B_out, 32'h40000000);
    watch_commit(1'b0, 8'h00, rl, vh, vf, vl, rf);
    check("f4_valid_cycles", vh, 32'd32);
    check("f4_class", 32'(class_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Upstream feeder for the floating-point adder. It receives two 32-bit operands as a byte stream with a valid/ready handshake and assembles them in shadow registers. It then commits both operands atomically, classifies them, and resynchronises the adder with a one-cycle reset pulse. Finally it holds the operands stable for a fixed window long enough for one full adder pass.

## Interface

Parameters:
- HOLD_CYCLES, 32: cycles the committed operands are held with operands_valid high; ≥ 1; covers adder worst case (READ 3 + EQUALIZING 1 + OPERATION 1 + POS_OPERATION ≤ 26 + CHECK 1).
- TIMEOUT, 64: idle cycles tolerated inside a partial frame before it is discarded; ≥ 1.

Ports:
- clock_100kHz  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- byte_in  in  8  operand byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- op_A_out  out  [0:31]  committed operand A (bit 0 sign, [1:6] exponent, [7:31] mantissa); drives adder op_A_in.
- op_B_out  out  [0:31]  committed operand B; drives adder op_B_in.
- adder_rst_n  out  1  active-low reset to the adder; low one cycle per commit.
- operands_valid  out  1  high throughout the hold window.
- class_out  out  [0:3]  [0] A zero, [1] B zero, [2] A exponent = 63, [3] B exponent = 63.
- frame_error  out  1  one-cycle pulse when a partial frame times out.

## Operation

- One frame is 8 bytes: A then B, MSB-first. Byte 0 → op[0:7], byte 3 → op[24:31].
- A byte is accepted on a rising edge with byte_valid && byte_ready. byte_ready is decoded from the registered state: 1 in LOAD_A and LOAD_B, 0 elsewhere.
- States:
  - LOAD_A: accept 4 bytes into shadow_A (byte counter 0..3); after byte 3 → LOAD_B.
  - LOAD_B: accept 4 bytes into shadow_B. On the edge accepting byte 3, op_A_out/op_B_out load from the shadows (B including that byte) → CLASSIFY.
  - CLASSIFY: one cycle. adder_rst_n = 0. class_out registered from op_*_out. Hold counter loads HOLD_CYCLES-1 → HOLD.
  - HOLD: operands_valid = 1; counter decrements; at 0 → LOAD_A with counter cleared.
- Zero: exponent == 0 and mantissa == 0. Sign is ignored, so -0 is zero.
- Timeout: an idle counter runs in LOAD_A with byte count > 0, and in LOAD_B. It clears on every accepted byte. Reaching TIMEOUT cycles without a byte discards the shadows, pulses frame_error, and goes to LOAD_A with count 0. op_*_out, class_out and the hold state are untouched.
- Bytes offered during CLASSIFY and HOLD are not accepted (byte_ready = 0). The source must hold them.
- op_*_out and class_out keep their values after HOLD until the next commit.

## Timing

- Reset (asynchronous, while reset = 0): state LOAD_A, counters 0, op_A_out = op_B_out = 0, class_out = 0, operands_valid = 0, frame_error = 0, adder_rst_n = 0. byte_ready becomes 1 on the first edge after release.
- Latency: let edge N accept the 8th byte.
  - op_*_out update at edge N.
  - adder_rst_n is low during cycle N→N+1.
  - class_out is valid and operands_valid rises at edge N+1.
  - operands_valid falls at edge N+1+HOLD_CYCLES; byte_ready rises at the same edge.
- Minimum frame period with no backpressure: 8 + 1 + HOLD_CYCLES cycles.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(TIMEOUT+1). No wrap is permitted; each counter saturates at its terminal value.
- Reset mid-frame or mid-HOLD aborts immediately. No partial frame survives.
- A timeout firing on the same edge as an accepted byte cannot occur, because acceptance clears the idle counter first.

## Structure

- Shared package fp_pkg:
  - FP_W = 32, EXP_W = 6, MANT_W = 25, EXP_MAX = 6'd63.
  - Field index constants: SIGN = 0, EXP [1:6], MANT [7:31].
  - Enum loader_state_t {LOAD_A, LOAD_B, CLASSIFY, HOLD}.
- Sub-module fp_classify: combinational; one operand in, {is_zero, is_exp_max} out. Instantiated twice.

## Test plan

- Bytes 3F 80 00 00 40 00 00 00 back-to-back → op_A_out = 32'h3F800000 and op_B_out = 32'h40000000 at the 8th edge; adder_rst_n low exactly one cycle; operands_valid high exactly 32 cycles; class_out = 4'b0000.
- Same frame with byte_valid dropped for 5 cycles between every byte → identical outputs; byte_ready stays 1 while waiting.
- 3 bytes of A, then 64 idle cycles → frame_error pulses once; op_*_out unchanged. A following full frame loads correctly.
- A = 32'h80000000, B = 32'h7E000001 → class_out = 4'b1001 (A zero; B exponent 63).
- Assert reset during HOLD cycle 10 → all outputs return to reset values asynchronously; byte_ready = 1 one edge after release.
- byte_valid held high with data during HOLD → no byte accepted; the next frame starts only after operands_valid falls.
